store_byte_serializer: RTL and testbench

//  Narrowing counterpart to the datapath's 16->32 sign/zero extender: takes a 32-bit

---
 rtl/store_byte_serializer_pkg.sv | 69 ++++++
 rtl/store_byte_serializer.sv | 115 +++++++++++
 tb/tb_store_byte_serializer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_byte_serializer_pkg.sv
// rtl/store_byte_serializer_pkg.sv - store size codes, FSM states and byte-lane helpers
//
// Purpose: definitions used by the store byte serializer. The size codes match the
//          encoding that the load-side extender path uses.
// Contents:
//   SIZE_BYTE/HALF/WORD/BAD  request size codes
//   stateE                   serializer FSM state (one state bit)
//   isLegal()                size/alignment check made at acceptance
//   lastIndex()              index of the final byte of a request
//   laneSelect()             big-endian byte-lane pick for a given byte index

package store_byte_serializer_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } stateE;

    // A request is legal when its size code is defined and the address is
    // naturally aligned for that size.
    function automatic logic isLegal(input logic [1:0] size, input logic [1:0] addrLow);
        logic legal;
        legal = 1'b0;
        case (size)
            SIZE_BYTE: legal = 1'b1;
            SIZE_HALF: legal = (addrLow[0] == 1'b0);
            SIZE_WORD: legal = (addrLow == 2'b00);
            default:   legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic [1:0] lastIndex(input logic [1:0] size);
        logic [1:0] last;
        last = 2'd0;
        case (size)
            SIZE_HALF: last = 2'd1;
            SIZE_WORD: last = 2'd3;
            default:   last = 2'd0;
        endcase
        return last;
    endfunction

    // Byte at the lowest address is the most significant byte of the value.
    function automatic logic [7:0] laneSelect(input logic [1:0] size, input logic [1:0] cnt,
                                              input logic [31:0] data);
        logic [7:0] lane;
        lane = data[7:0];
        case (size)
            SIZE_HALF: lane = cnt[0] ? data[7:0] : data[15:8];
            SIZE_WORD: begin
                case (cnt)
                    2'd0:    lane = data[31:24];
                    2'd1:    lane = data[23:16];
                    2'd2:    lane = data[15:8];
                    default: lane = data[7:0];
                endcase
            end
            default:   lane = data[7:0];
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/store_byte_serializer.sv
// rtl/store_byte_serializer.sv - serialises byte/half/word stores into big-endian byte writes
//
// Purpose: sits between the pipeline MEM stage and an 8-bit data memory. Accepts one
//          store request at a time, checks alignment, then issues one byte write per
//          memory acknowledge. Reports a single done or err pulse per accepted request.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_addr/data/size    store address, register value, size code
//   mem_wr_en/addr/wdata  byte write to memory, held until mem_ack
//   mem_ack               memory accepts the current byte this cycle
//   done                  one-cycle pulse after the last byte is acknowledged
//   err                   one-cycle pulse for a rejected request (no writes issued)

module store_byte_serializer
    import store_byte_serializer_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    output logic              done,
    output logic              err
);

    stateE             state, stateNext;
    logic [1:0]        cnt, cntNext;
    logic [1:0]        lastCnt, lastNext;
    logic [31:0]       dataQ, dataNext;
    logic [1:0]        sizeQ, sizeNext;
    logic [ADDR_W-1:0] addrNext;
    logic [7:0]        wdataNext;
    logic              doneNext, errNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 2'd0;
            lastCnt   <= 2'd0;
            dataQ     <= 32'd0;
            sizeQ     <= SIZE_BYTE;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            lastCnt   <= lastNext;
            dataQ     <= dataNext;
            sizeQ     <= sizeNext;
            mem_addr  <= addrNext;
            mem_wdata <= wdataNext;
            done      <= doneNext;
            err       <= errNext;
        end
    end

    // mem_addr tracks latched address + cnt by incrementing alongside cnt, and
    // mem_wdata is preloaded with the next lane so both outputs come straight from flops.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        lastNext  = lastCnt;
        dataNext  = dataQ;
        sizeNext  = sizeQ;
        addrNext  = mem_addr;
        wdataNext = mem_wdata;
        doneNext  = 1'b0;
        errNext   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (isLegal(req_size, req_addr[1:0])) begin
                        stateNext = ST_WRITE;
                        cntNext   = 2'd0;
                        lastNext  = lastIndex(req_size);
                        dataNext  = req_data;
                        sizeNext  = req_size;
                        addrNext  = req_addr;
                        wdataNext = laneSelect(req_size, 2'd0, req_data);
                    end else begin
                        errNext = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    if (cnt == lastCnt) begin
                        stateNext = ST_IDLE;
                        doneNext  = 1'b1;
                    end else begin
                        cntNext   = cnt + 2'd1;
                        addrNext  = mem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                        wdataNext = laneSelect(sizeQ, cnt + 2'd1, dataQ);
                    end
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    assign req_ready = (state == ST_IDLE);
    assign mem_wr_en = (state == ST_WRITE);

endmodule

// File: tb/tb_store_byte_serializer.sv
// tb/tb_store_byte_serializer.sv - self-checking bench for store_byte_serializer

module tb_store_byte_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_data = 32'd0;
    logic [1:0]  req_size = 2'd0;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic        done;
    logic        err;

    int testsRun = 0;
    int testsFailed = 0;

    // observations of the last request
    logic [31:0] obsA[$];
    logic [7:0]  obsD[$];
    logic [31:0] trA[$];
    logic [7:0]  trD[$];
    int doneCnt, errCnt, doneAt, errAt, readyBad, bothBad;

    // reference expectations
    logic [31:0] expA[$];
    logic [7:0]  expD[$];
    bit          expLegal;

    store_byte_serializer #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Reference: n = 2^size bytes, legal iff size defined and addr multiple of n;
    // byte i goes to addr+i and carries the i-th most significant byte of the low n bytes.
    function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        int n;
        expA.delete();
        expD.delete();
        expLegal = 1'b0;
        if (s == 2'b11) return;
        n = 1 << s;
        if ((a % 32'(n)) != 0) return;
        expLegal = 1'b1;
        for (int i = 0; i < n; i++) begin
            expA.push_back(a + 32'(i));
            expD.push_back(8'((d >> (8 * (n - 1 - i))) & 32'hFF));
        end
    endfunction

    // ackMode: 0 ack always, 1 random ack, 2 ack held low for the first 3 cycles
    task automatic doReq(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                         input int ackMode);
        int tail;
        obsA.delete(); obsD.delete(); trA.delete(); trD.delete();
        doneCnt = 0; errCnt = 0; doneAt = -1; errAt = -1; readyBad = 0; bothBad = 0;
        tail = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_data = $urandom; req_size = 2'($urandom_range(0, 3));
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            case (ackMode)
                0:       mem_ack = 1'b1;
                1:       mem_ack = ($urandom_range(0, 2) != 0);
                default: mem_ack = (cyc > 3);
            endcase
            if (mem_wr_en) begin
                trA.push_back(mem_addr); trD.push_back(mem_wdata);
                if (mem_ack) begin obsA.push_back(mem_addr); obsD.push_back(mem_wdata); end
                if (req_ready) readyBad++;
            end
            if (done) begin doneCnt++; if (doneAt < 0) doneAt = cyc; end
            if (err) begin errCnt++; if (errAt < 0) errAt = cyc; end
            if (done && err) bothBad++;
            if (doneCnt + errCnt > 0) tail++;
            if (tail >= 3) break;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        testsRun++;
        if (req_ready !== 1'b1) begin testsFailed++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        testsRun++;
        if (mem_wr_en !== 1'b0) begin testsFailed++; $display("FAIL reset_wr_en: got %b expected 0", mem_wr_en); end
        testsRun++;
        if (mem_addr !== 32'd0 || mem_wdata !== 8'd0) begin
            testsFailed++; $display("FAIL reset_addr_data: got %h/%h expected 0/0", mem_addr, mem_wdata);
        end
        testsRun++;
        if (done !== 1'b0 || err !== 1'b0) begin
            testsFailed++; $display("FAIL reset_pulses: got done=%b err=%b expected 0/0", done, err);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word();
        model(32'h100, 32'hDEADBEEF, 2'b10);
        doReq(32'h100, 32'hDEADBEEF, 2'b10, 0);
        testsRun++;
        if (obsA.size() != expA.size()) begin
            testsFailed++; $display("FAIL word_count: got %0d writes expected %0d", obsA.size(), expA.size());
        end else begin
            for (int i = 0; i < expA.size(); i++) begin
                testsRun++;
                if (obsA[i] !== expA[i] || obsD[i] !== expD[i]) begin
                    testsFailed++;
                    $display("FAIL word_byte%0d: got %h:%h expected %h:%h", i, obsA[i], obsD[i], expA[i], expD[i]);
                end
            end
        end
        testsRun++;
        if (doneCnt != 1 || doneAt != 5) begin
            testsFailed++; $display("FAIL word_done: got count=%0d at=%0d expected 1 at 5", doneCnt, doneAt);
        end
        testsRun++;
        if (readyBad != 0) begin testsFailed++; $display("FAIL word_ready_low: got %0d ready cycles expected 0", readyBad); end
    endtask

    task automatic test_half_wait();
        int held;
        model(32'h202, 32'h1234ABCD, 2'b01);
        doReq(32'h202, 32'h1234ABCD, 2'b01, 2);
        held = 0;
        foreach (trA[i]) if (trA[i] == 32'h202 && trD[i] == 8'hAB) held++;
        testsRun++;
        if (held != 4) begin testsFailed++; $display("FAIL half_hold: got %0d cycles expected 4", held); end
        testsRun++;
        if (obsA.size() != 2 || obsA[0] !== expA[0] || obsD[0] !== expD[0] ||
            obsA[1] !== expA[1] || obsD[1] !== expD[1]) begin
            testsFailed++; $display("FAIL half_writes: got %0d writes expected 202:AB 203:CD", obsA.size());
        end
        testsRun++;
        if (doneCnt != 1 || doneAt != 6) begin
            testsFailed++; $display("FAIL half_done: got count=%0d at=%0d expected 1 at 6", doneCnt, doneAt);
        end
    endtask

    task automatic test_byte();
        model(32'h7, 32'h000000FF, 2'b00);
        doReq(32'h7, 32'h000000FF, 2'b00, 0);
        testsRun++;
        if (obsA.size() != 1 || obsA[0] !== expA[0] || obsD[0] !== expD[0]) begin
            testsFailed++; $display("FAIL byte_write: got %0d writes expected 1 write 7:FF", obsA.size());
        end
        testsRun++;
        if (doneCnt != 1 || doneAt != 2) begin
            testsFailed++; $display("FAIL byte_done: got count=%0d at=%0d expected 1 at 2", doneCnt, doneAt);
        end
    endtask

    task automatic test_errors();
        logic [31:0] a[3] = '{32'h102, 32'h5, 32'h0};
        logic [1:0]  s[3] = '{2'b10, 2'b01, 2'b11};
        for (int k = 0; k < 3; k++) begin
            doReq(a[k], $urandom, s[k], 0);
            testsRun++;
            if (errCnt != 1 || errAt != 1 || doneCnt != 0 || trA.size() != 0) begin
                testsFailed++;
                $display("FAIL err_case%0d: got err=%0d at=%0d done=%0d wr_cycles=%0d expected 1/1/0/0",
                         k, errCnt, errAt, doneCnt, trA.size());
            end
        end
    endtask

    task automatic test_back_to_back();
        int seenDoneReady, wr2At;
        obsA.delete(); obsD.delete();
        doneCnt = 0; seenDoneReady = 0; wr2At = -1;
        mem_ack = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h40; req_data = 32'h11; req_size = 2'b00;
        @(posedge clk);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin req_addr = 32'h41; req_data = 32'h22; end
            if (cyc == 3) req_valid = 1'b0;
            if (mem_wr_en && mem_ack) begin
                obsA.push_back(mem_addr); obsD.push_back(mem_wdata);
                if (mem_addr == 32'h41 && wr2At < 0) wr2At = cyc;
            end
            if (done) begin doneCnt++; if (cyc == 2 && req_ready) seenDoneReady = 1; end
        end
        mem_ack = 1'b0;
        testsRun++;
        if (seenDoneReady != 1 || wr2At != 3) begin
            testsFailed++; $display("FAIL b2b_timing: got done_ready=%0d wr2_at=%0d expected 1/3", seenDoneReady, wr2At);
        end
        testsRun++;
        if (obsA.size() != 2 || doneCnt != 2 || obsA[0] !== 32'h40 || obsD[0] !== 8'h11 ||
            obsA[1] !== 32'h41 || obsD[1] !== 8'h22) begin
            testsFailed++; $display("FAIL b2b_writes: got %0d writes %0d done expected 2/2", obsA.size(), doneCnt);
        end
    endtask

    task automatic test_reset_midrequest();
        int doneSeen;
        obsA.delete(); obsD.delete(); doneSeen = 0;
        mem_ack = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h400; req_data = 32'hCAFEF00D; req_size = 2'b10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int cyc = 1; cyc <= 2; cyc++) begin
            @(negedge clk);
            if (mem_wr_en && mem_ack) begin obsA.push_back(mem_addr); obsD.push_back(mem_wdata); end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        testsRun++;
        if (mem_wr_en !== 1'b0 || req_ready !== 1'b1 || mem_addr !== 32'd0 || mem_wdata !== 8'd0) begin
            testsFailed++;
            $display("FAIL rst_mid_outputs: got wr_en=%b ready=%b addr=%h wdata=%h expected 0/1/0/0",
                     mem_wr_en, req_ready, mem_addr, mem_wdata);
        end
        repeat (2) begin
            @(negedge clk);
            if (done || err) doneSeen++;
        end
        rst_n = 1'b1;
        mem_ack = 1'b0;
        testsRun++;
        if (doneSeen != 0 || obsA.size() != 2 || obsD[0] !== 8'hCA || obsD[1] !== 8'hFE) begin
            testsFailed++; $display("FAIL rst_mid_state: got pulses=%0d writes=%0d expected 0/2", doneSeen, obsA.size());
        end
        model(32'h8, 32'h5A5A1234, 2'b01);
        doReq(32'h8, 32'h5A5A1234, 2'b01, 0);
        testsRun++;
        if (obsA.size() != 2 || obsA[0] !== expA[0] || obsD[0] !== expD[0] ||
            obsA[1] !== expA[1] || obsD[1] !== expD[1] || doneCnt != 1 || doneAt != 3) begin
            testsFailed++; $display("FAIL rst_mid_after: got %0d writes done=%0d at=%0d expected 2/1/3",
                                    obsA.size(), doneCnt, doneAt);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic [1:0]  s;
        int mode, ok;
        for (int it = 0; it < 40; it++) begin
            s = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
            d = $urandom;
            mode = $urandom_range(0, 1);
            model(a, d, s);
            doReq(a, d, s, mode);
            ok = (obsA.size() == expA.size()) && (bothBad == 0);
            if (ok) foreach (expA[i]) if (obsA[i] !== expA[i] || obsD[i] !== expD[i]) ok = 0;
            if (expLegal) ok = ok && doneCnt == 1 && errCnt == 0 && (mode != 0 || doneAt == expA.size() + 1);
            else ok = ok && errCnt == 1 && doneCnt == 0 && trA.size() == 0;
            testsRun++;
            if (!ok) begin
                testsFailed++;
                $display("FAIL rand%0d: addr=%h size=%0d got writes=%0d done=%0d err=%0d expected writes=%0d legal=%0d",
                         it, a, s, obsA.size(), doneCnt, errCnt, expA.size(), expLegal);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_half_wait();
        test_byte();
        test_errors();
        test_back_to_back();
        test_reset_midrequest();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
